// File: rtl/bip_acc_ctrl.sv
// BIP accumulator/execute stage: accepts decoded ops, sequences data RAM
// accesses, feeds the external ADD/SUB units and captures results into ACC.
module bip_acc_ctrl #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 11,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sel,
  input  logic [DATA_W-1:0] alu_z,
  output logic [DATA_W-1:0] acc,
  output logic              done,
  output logic              halted,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

  typedef enum logic [1:0] {IDLE, MEM, EXEC, HALT} state_t;

  state_t            state, state_n;
  logic [OPC_W-1:0]  opcode_q;
  logic [DATA_W-1:0] operand_q;
  logic              accept;
  logic              in_is_mem;
  logic              q_is_sto;
  logic              q_mem_src;
  logic              q_arith;
  logic [DATA_W-1:0] b_eff;
  logic              ovf_n;

  assign in_is_mem = (opcode == OP_STO) || (opcode == OP_LD) ||
                     (opcode == OP_ADD) || (opcode == OP_SUB);
  assign q_is_sto  = (opcode_q == OP_STO);
  assign q_mem_src = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);
  assign q_arith   = q_mem_src || (opcode_q == OP_ADDI) || (opcode_q == OP_SUBI);
  assign accept    = op_valid && op_ready;

  assign mem_addr  = operand_q[ADDR_W-1:0];
  assign mem_wdata = acc;
  assign alu_a     = acc;
  assign alu_b     = q_mem_src ? mem_rdata : operand_q;
  assign alu_sel   = (opcode_q == OP_SUB) || (opcode_q == OP_SUBI);
  assign zero      = (acc == '0);
  assign neg       = acc[DATA_W-1];

  // Subtraction overflows like an add of the inverted subtrahend.
  assign b_eff = alu_sel ? ~alu_b : alu_b;
  assign ovf_n = (acc[DATA_W-1] == b_eff[DATA_W-1]) &&
                 (alu_z[DATA_W-1] != acc[DATA_W-1]);

  always_comb begin
    state_n  = state;
    op_ready = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (opcode == OP_HLT) state_n = HALT;
          else if (in_is_mem)   state_n = MEM;
          else                  state_n = EXEC;
        end
      end
      MEM: begin
        mem_wr  = q_is_sto;
        mem_rd  = !q_is_sto;
        state_n = q_is_sto ? IDLE : EXEC;
      end
      EXEC:    state_n = IDLE;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
      acc       <= '0;
      done      <= 1'b0;
      halted    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= (state == EXEC) || ((state == MEM) && q_is_sto);
      if (accept) begin
        opcode_q  <= opcode;
        operand_q <= operand;
        if (opcode == OP_HLT) halted <= 1'b1;
      end
      if (state == EXEC) begin
        if (opcode_q == OP_LD)       acc <= mem_rdata;
        else if (opcode_q == OP_LDI) acc <= operand_q;
        else if (q_arith)            acc <= alu_z;
        if (q_arith) ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_bip_acc_ctrl.sv
// Self-checking bench for bip_acc_ctrl with behavioural RAM/ALU and an
// instruction-level reference model of the accumulator machine.
module tb_bip_acc_ctrl;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [4:0]   opcode = '0;
  logic [W-1:0] operand = '0;
  logic [W-1:0] mem_addr;
  logic         mem_rd, mem_wr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic         alu_sel;
  logic [W-1:0] acc;
  logic         done, halted, zero, neg, ovf;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] ram [0:2047];
  logic [W-1:0] m_mem [0:2047];
  logic [W-1:0] m_acc;
  logic         m_ovf;

  always #5 clk = ~clk;

  assign alu_z = alu_sel ? (alu_a - alu_b) : (alu_a + alu_b);

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= mem_wdata;
  end

  bip_acc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .operand(operand), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_z(alu_z),
    .acc(acc), .done(done), .halted(halted), .zero(zero), .neg(neg), .ovf(ovf)
  );

  function automatic int sx(input logic [W-1:0] v);
    return (v >= 1024) ? int'(v) - 2048 : int'(v);
  endfunction

  // Architectural effect of one op, using signed integer arithmetic.
  task automatic model_exec(input int opc, input logic [W-1:0] opd);
    int s;
    logic [W-1:0] b;
    case (opc)
      1: m_mem[opd] = m_acc;
      2: m_acc = m_mem[opd];
      3: m_acc = opd;
      4, 5, 6, 7: begin
        b = (opc == 4 || opc == 6) ? m_mem[opd] : opd;
        s = (opc < 6) ? sx(m_acc) + sx(b) : sx(m_acc) - sx(b);
        m_ovf = (s > 1023) || (s < -1024);
        m_acc = W'(s & 'h7FF);
      end
      default: ;
    endcase
  endtask

  // Issues one op from a negedge, runs it to done and checks everything.
  task automatic send_op(input int opc, input logic [W-1:0] opd);
    int n, rd_cnt, wr_cnt, exp_lat, exp_rd, exp_wr;
    logic sel_last;
    logic [W-1:0] addr_seen, wdata_seen;
    exp_lat = (opc == 2 || opc == 4 || opc == 6) ? 3 : 2;
    exp_rd  = (opc == 2 || opc == 4 || opc == 6) ? 1 : 0;
    exp_wr  = (opc == 1) ? 1 : 0;
    total++;
    if (op_ready !== 1'b1) $display("FAIL ready_idle op=%0d got=%b exp=1", opc, op_ready);
    else passed++;
    op_valid = 1'b1; opcode = 5'(opc); operand = opd;
    @(posedge clk);
    #1 op_valid = 1'b0;
    model_exec(opc, opd);
    n = 0; rd_cnt = 0; wr_cnt = 0; sel_last = 1'b0;
    addr_seen = '0; wdata_seen = '0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        total++;
        if (op_ready !== 1'b0) $display("FAIL ready_busy op=%0d got=%b exp=0", opc, op_ready);
        else passed++;
      end
      if (!done) begin
        sel_last = alu_sel;
        if (mem_rd) begin rd_cnt++; addr_seen = mem_addr; end
        if (mem_wr) begin wr_cnt++; addr_seen = mem_addr; wdata_seen = mem_wdata; end
      end
    end while (!done && n < 6);
    total++;
    if (n !== exp_lat || !done) $display("FAIL latency op=%0d got=%0d exp=%0d", opc, n, exp_lat);
    else passed++;
    total++;
    if (acc !== m_acc) $display("FAIL acc op=%0d opd=%h got=%h exp=%h", opc, opd, acc, m_acc);
    else passed++;
    total++;
    if (ovf !== m_ovf) $display("FAIL ovf op=%0d got=%b exp=%b", opc, ovf, m_ovf);
    else passed++;
    total++;
    if (zero !== (m_acc == 0) || neg !== m_acc[W-1])
      $display("FAIL flags op=%0d got z=%b n=%b exp z=%b n=%b", opc, zero, neg, m_acc == 0, m_acc[W-1]);
    else passed++;
    total++;
    if (rd_cnt !== exp_rd || wr_cnt !== exp_wr)
      $display("FAIL strobes op=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", opc, rd_cnt, wr_cnt, exp_rd, exp_wr);
    else passed++;
    if (exp_rd + exp_wr > 0) begin
      total++;
      if (addr_seen !== opd) $display("FAIL mem_addr op=%0d got=%h exp=%h", opc, addr_seen, opd);
      else passed++;
    end
    if (exp_wr > 0) begin
      total++;
      if (wdata_seen !== m_mem[opd]) $display("FAIL wdata got=%h exp=%h", wdata_seen, m_mem[opd]);
      else passed++;
    end
    total++;
    if (sel_last !== (opc == 6 || opc == 7)) $display("FAIL alu_sel op=%0d got=%b", opc, sel_last);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; op_valid = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (acc !== 0 || done !== 0 || halted !== 0 || ovf !== 0 || mem_rd !== 0 || mem_wr !== 0)
      $display("FAIL reset_state got acc=%h done=%b halt=%b ovf=%b rd=%b wr=%b exp all 0",
               acc, done, halted, ovf, mem_rd, mem_wr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (op_ready !== 1'b1 || zero !== 1'b1) $display("FAIL reset_ready got=%b z=%b exp 1 1", op_ready, zero);
    else passed++;
  endtask

  task automatic test_ldi();
    send_op(3, 11'h005);
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL done_single got=%b exp=0", done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    send_op(3, 11'h003);
    send_op(7, 11'h005);
    total++;
    if (acc !== 11'h7FE || neg !== 1'b1 || ovf !== 1'b0)
      $display("FAIL subi_neg got acc=%h neg=%b ovf=%b exp 7fe 1 0", acc, neg, ovf);
    else passed++;
  endtask

  task automatic test_sto_ld();
    send_op(3, 11'h123);
    send_op(1, 11'h010);
    send_op(3, 11'h000);
    send_op(2, 11'h010);
    total++;
    if (acc !== 11'h123) $display("FAIL ld_back got=%h exp=123", acc);
    else passed++;
  endtask

  task automatic test_ovf();
    send_op(3, 11'h3FF);
    send_op(5, 11'h001);
    send_op(7, 11'h001);
    send_op(3, 11'h000);
    total++;
    if (ovf !== 1'b1 || zero !== 1'b1) $display("FAIL ovf_hold got ovf=%b z=%b exp 1 1", ovf, zero);
    else passed++;
  endtask

  task automatic test_halt();
    logic [W-1:0] held;
    held = acc;
    op_valid = 1'b1; opcode = 5'd0; operand = '0;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || op_ready !== 1'b0) $display("FAIL halt got halted=%b ready=%b exp 1 0", halted, op_ready);
    else passed++;
    op_valid = 1'b1; opcode = 5'd3; operand = 11'h055;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || acc !== held || mem_rd !== 0 || mem_wr !== 0)
        $display("FAIL halt_idle cyc=%0d got done=%b acc=%h exp 0 %h", i, done, acc, held);
      else passed++;
    end
    op_valid = 1'b0;
    do_reset();
    total++;
    if (halted !== 1'b0 || op_ready !== 1'b1) $display("FAIL halt_reset got halted=%b ready=%b exp 0 1", halted, op_ready);
    else passed++;
  endtask

  task automatic test_reset_abort();
    ram[11'h020] = 11'h111; m_mem[11'h020] = 11'h111;
    op_valid = 1'b1; opcode = 5'd4; operand = 11'h020;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1) $display("FAIL abort_mem got rd=%b exp=1", mem_rd);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (mem_rd !== 1'b0) $display("FAIL abort_async got rd=%b exp=0", mem_rd);
    else passed++;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || acc !== 0 || op_ready !== 1'b1)
        $display("FAIL abort_after cyc=%0d got done=%b acc=%h ready=%b exp 0 0 1", i, done, acc, op_ready);
      else passed++;
    end
  endtask

  task automatic test_random();
    int opc;
    logic [W-1:0] opd;
    for (int i = 0; i < 60; i++) begin
      opc = $urandom_range(1, 15);
      if (opc == 1 || opc == 2 || opc == 4 || opc == 6) opd = W'($urandom_range(0, 15));
      else opd = W'($urandom);
      send_op(opc, opd);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin ram[i] = '0; m_mem[i] = '0; end
    mem_rdata = '0;
    m_acc = '0; m_ovf = 1'b0;
    test_reset();
    test_ldi();
    test_back_to_back();
    test_sto_ld();
    test_ovf();
    test_halt();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim did not finish");
    $fatal(1);
  end
endmodule
